program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Generates the program-memory fetch address (`pm_addr`) that feeds the instruction decoder.
- Consumes the decoder's `jmp`, `jmp_nz` and `ir_nibble` results and the ALU zero flag.
- Adds a debug run/halt/single-step controller and an executed-instruction counter.
- Sits between the instruction decoder and program memory in the CME341 processor datapath.

Parameters:
- PC_W, 8, width of the program counter and `pm_addr`.
- CNT_W, 16, width of the executed-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sync_reset  input  1  processor synchronous reset, active-high; forces fetch from address 0.
- jmp  input  1  unconditional jump decoded this cycle.
- jmp_nz  input  1  conditional jump decoded this cycle.
- jump_addr  input  4  jump target nibble (the decoder's `ir_nibble`).
- dont_jmp  input  1  ALU zero flag; when 1, a conditional jump is not taken.
- halt_req  input  1  level; debug request to stop fetching.
- step_req  input  1  level; a rising edge advances one instruction while halted.
- pm_addr  output  PC_W  program-memory address (combinational).
- pc  output  PC_W  registered address of the instruction now in `ir`.
- halted  output  1  1 while in HALT; downstream forces NOP into `ir`.
- step_ack  output  1  one-cycle pulse when a single step is performed.
- instr_count  output  CNT_W  count of cycles in which an instruction advanced.
- from_PS  output  8  debug tap; equals `pc[7:0]`.

Behaviour:
Reset:
- `reset_n` low (asynchronous) sets state=RUN, pc=0, step_req_d=0, instr_count=0.
- While in reset, outputs are: pm_addr=0, halted=0, step_ack=0, from_PS=0.
- Release is synchronous to the next `clk` edge; the first post-reset fetch is address 0.

Next-address logic, combinational, in priority order:
1. `sync_reset`=1 -> pm_addr=0.
2. state==HALT -> pm_addr=pc (refetch; no advance; `jmp`/`jmp_nz` ignored).
3. `jmp`=1 -> pm_addr={jump_addr, 4'h0}.
4. `jmp_nz`=1 and `dont_jmp`=0 -> pm_addr={jump_addr, 4'h0}.
5. Otherwise pm_addr=pc+1, modulo 2^PC_W (8'hFF wraps to 8'h00).
- `jmp` and `jmp_nz` both high cannot occur; if it does, `jmp` wins.

PC register:
- pc <= pm_addr every cycle.
- Latency: `pm_addr` to `pc` is 1 cycle; `jump_addr` to the target appearing on `pm_addr` is 0 cycles.

State machine (states RUN, HALT, STEP):
- step_req_d <= step_req every cycle; step_edge = step_req & ~step_req_d.
- RUN: `halt_req`=1 -> HALT; else stay in RUN. `step_edge` is ignored.
- HALT, first match wins:
  - `step_edge`=1 -> STEP.
  - `halt_req`=0 -> RUN.
  - otherwise stay in HALT.
- STEP: lasts exactly 1 cycle and uses normal next-address logic, so jumps are honoured. `step_ack`=1 during this cycle only. Next state: HALT if `halt_req`=1, else RUN.
- `halted` = (state==HALT).
- `sync_reset`=1 does not change state but forces pm_addr=0 (priority 1 above), including while in HALT; pc therefore becomes 0.
- `reset_n` asserted mid-step aborts to RUN with pc=0; `step_ack` drops immediately.

Counter:
- instr_count increments when state!=HALT and `sync_reset`=0.
- It saturates at all-ones and is never cleared except by `reset_n`.
- from_PS = pc.

Test Plan:
1. reset_n 0->1, all inputs 0, run 5 cycles -> pm_addr 1,2,3,4,5; pc lags pm_addr by one cycle; instr_count=5.
2. Preset pc=8'hFE, free-run 3 cycles -> pm_addr FF, 00, 01 (wrap-around).
3. jmp=1 with jump_addr=4'hA -> pm_addr=8'hA0 the same cycle, pc=8'hA0 the next cycle. Then jmp_nz=1, jump_addr=3: dont_jmp=1 -> pm_addr=8'hA1; dont_jmp=0 -> pm_addr=8'h30.
4. halt_req=1 at pc=8'h12 -> halted=1 next cycle; pm_addr and pc hold at 8'h13 for 10 cycles with jmp=1 asserted (jump ignored); instr_count frozen.
5. While halted, pulse step_req high for 3 cycles -> exactly one step_ack; pc advances by one (8'h13 -> 8'h14); returns to HALT. Then drop halt_req -> RUN, halted=0.
6. Assert reset_n=0 asynchronously during STEP -> pc, instr_count and step_ack clear immediately without a clock edge. Separately, sync_reset=1 while halted -> pm_addr=0, pc=0, state stays HALT.

Source files
------------

// File: rtl/program_sequencer.sv
// Program sequencer: program-memory fetch address generation with a debug
// run/halt/single-step controller and an executed-instruction counter.
module program_sequencer #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sync_reset,
  input  logic             jmp,
  input  logic             jmp_nz,
  input  logic [3:0]       jump_addr,
  input  logic             dont_jmp,
  input  logic             halt_req,
  input  logic             step_req,
  output logic [PC_W-1:0]  pm_addr,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic             step_ack,
  output logic [CNT_W-1:0] instr_count,
  output logic [7:0]       from_PS
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t state;
  logic   step_req_d;
  logic   step_edge;

  // Only a fresh rising edge of the step request may trigger a step.
  assign step_edge = step_req & ~step_req_d;

  // Next fetch address, in priority order; reset holds the fetch at 0.
  always_comb begin
    pm_addr = pc + PC_W'(1);
    if (!reset_n || sync_reset) begin
      pm_addr = '0;
    end else if (state == HALT) begin
      pm_addr = pc;
    end else if (jmp || (jmp_nz && !dont_jmp)) begin
      pm_addr = PC_W'({jump_addr, 4'h0});
    end
  end

  // Program counter follows the fetch address one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= '0;
    end else begin
      pc <= pm_addr;
    end
  end

  // Step request delay stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_req_d <= 1'b0;
    end else begin
      step_req_d <= step_req;
    end
  end

  // Debug controller; halted and step_ack are registered with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      halted   <= 1'b0;
      step_ack <= 1'b0;
    end else begin
      step_ack <= 1'b0;
      case (state)
        RUN: begin
          if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (step_edge) begin
            state    <= STEP;
            halted   <= 1'b0;
            step_ack <= 1'b1;
          end else if (!halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        STEP: begin
          if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which an instruction advanced.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_count <= '0;
    end else if ((state != HALT) && !sync_reset && (instr_count != {CNT_W{1'b1}})) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign from_PS = 8'(pc);

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT.
module tb_program_sequencer;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             sync_reset;
  logic             jmp;
  logic             jmp_nz;
  logic [3:0]       jump_addr;
  logic             dont_jmp;
  logic             halt_req;
  logic             step_req;
  logic [PC_W-1:0]  pm_addr;
  logic [PC_W-1:0]  pc;
  logic             halted;
  logic             step_ack;
  logic [CNT_W-1:0] instr_count;
  logic [7:0]       from_PS;

  program_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_reset (sync_reset),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .jump_addr  (jump_addr),
    .dont_jmp   (dont_jmp),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .pm_addr    (pm_addr),
    .pc         (pc),
    .halted     (halted),
    .step_ack   (step_ack),
    .instr_count(instr_count),
    .from_PS    (from_PS)
  );

  always #5 clk = ~clk;

  typedef enum int {K_PM, K_PC, K_HALT, K_ACK, K_CNT, K_FROM} kind_t;
  typedef struct {
    kind_t       k;
    int unsigned v;
    string       nm;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int unsigned act;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_exp = 0;

  task automatic want(input kind_t k, input int unsigned v, input string nm);
    exp_t e;
    e.k  = k;
    e.v  = v;
    e.nm = nm;
    q.push_back(e);
  endtask

  // Clock edge in which an instruction advances.
  task automatic tick();
    @(posedge clk);
    #1;
    n_exp = n_exp + 1;
  endtask

  // Clock edge with the counter frozen (halted, reset or sync_reset).
  task automatic tick_frozen();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation queued during the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      cur = q.pop_front();
      case (cur.k)
        K_PM:    act = 32'(pm_addr);
        K_PC:    act = 32'(pc);
        K_HALT:  act = 32'(halted);
        K_ACK:   act = 32'(step_ack);
        K_CNT:   act = 32'(instr_count);
        default: act = 32'(from_PS);
      endcase
      n_cmp = n_cmp + 1;
      if (act != cur.v) begin
        n_bad = n_bad + 1;
        $display("FAIL %s @%0t: got %0h, expected %0h", cur.nm, $time, act, cur.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; sync_reset = 1'b0; jmp = 1'b0; jmp_nz = 1'b0;
    jump_addr = 4'h0; dont_jmp = 1'b0; halt_req = 1'b0; step_req = 1'b0;

    // Reset state
    tick_frozen();
    tick_frozen();
    want(K_PM, 0, "rst_pm"); want(K_PC, 0, "rst_pc"); want(K_HALT, 0, "rst_halted");
    want(K_ACK, 0, "rst_ack"); want(K_CNT, 0, "rst_cnt"); want(K_FROM, 0, "rst_from");
    tick_frozen();

    // 1: free run from 0
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      want(K_PM, i + 1, "run_pm"); want(K_PC, i, "run_pc");
      tick();
    end
    want(K_PC, 5, "run_pc5"); want(K_CNT, n_exp, "run_cnt"); want(K_FROM, 5, "run_from");

    // 2: wrap-around from FE
    jmp = 1'b1; jump_addr = 4'hF;
    want(K_PM, 8'hF0, "jmp_f0");
    tick();
    jmp = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    want(K_PC, 8'hFE, "pre_fe"); want(K_PM, 8'hFF, "wrap_ff");
    tick();
    want(K_PM, 8'h00, "wrap_00"); want(K_PC, 8'hFF, "wrap_pc_ff");
    tick();
    want(K_PM, 8'h01, "wrap_01"); want(K_PC, 8'h00, "wrap_pc_00");
    tick();

    // 3: unconditional and conditional jumps
    jmp = 1'b1; jump_addr = 4'hA;
    want(K_PM, 8'hA0, "jmp_a0");
    tick();
    jmp = 1'b0; jmp_nz = 1'b1; jump_addr = 4'h3; dont_jmp = 1'b1;
    want(K_PC, 8'hA0, "jmp_pc_a0"); want(K_PM, 8'hA1, "jnz_not_taken");
    tick();
    dont_jmp = 1'b0;
    want(K_PM, 8'h30, "jnz_taken");
    tick();
    jmp_nz = 1'b0;
    want(K_PC, 8'h30, "jnz_pc_30"); want(K_CNT, n_exp, "jmp_cnt");

    // 4: halt at pc=12, jumps ignored while halted
    jmp = 1'b1; jump_addr = 4'h1;
    tick();
    jmp = 1'b0;
    tick();
    tick();
    halt_req = 1'b1;
    want(K_PC, 8'h12, "pre_halt_pc"); want(K_PM, 8'h13, "pre_halt_pm"); want(K_HALT, 0, "pre_halt");
    tick();
    jmp = 1'b1; jump_addr = 4'h7;
    for (int i = 0; i < 10; i++) begin
      want(K_PM, 8'h13, "halt_pm"); want(K_PC, 8'h13, "halt_pc");
      want(K_HALT, 1, "halt_flag"); want(K_CNT, n_exp, "halt_cnt");
      tick_frozen();
    end
    jmp = 1'b0;

    // 5: single step while halted, then resume
    step_req = 1'b1;
    want(K_PM, 8'h13, "step_edge_pm"); want(K_ACK, 0, "step_edge_ack");
    tick_frozen();
    want(K_ACK, 1, "step_ack"); want(K_PM, 8'h14, "step_pm");
    want(K_PC, 8'h13, "step_pc"); want(K_HALT, 0, "step_halted");
    tick();
    want(K_ACK, 0, "post_step_ack"); want(K_HALT, 1, "post_step_halted");
    want(K_PC, 8'h14, "post_step_pc"); want(K_PM, 8'h14, "post_step_pm");
    tick_frozen();
    step_req = 1'b0;
    want(K_ACK, 0, "held_step_ack"); want(K_PC, 8'h14, "held_step_pc");
    want(K_CNT, n_exp, "step_cnt");
    tick_frozen();
    halt_req = 1'b0;
    want(K_PM, 8'h14, "resume_pm_halt");
    tick_frozen();
    want(K_HALT, 0, "resume_halted"); want(K_PM, 8'h15, "resume_pm"); want(K_PC, 8'h14, "resume_pc");
    tick();

    // 6a: asynchronous reset in the middle of a step
    halt_req = 1'b1;
    tick();
    step_req = 1'b1;
    tick_frozen();
    reset_n = 1'b0; step_req = 1'b0; halt_req = 1'b0;
    #1;
    if (pc != 8'h00) begin
      n_bad = n_bad + 1;
      $display("FAIL async_pc_now: got %0h, expected 0", pc);
    end
    if (step_ack != 1'b0) begin
      n_bad = n_bad + 1;
      $display("FAIL async_ack_now: got %0h, expected 0", step_ack);
    end
    if (instr_count != '0) begin
      n_bad = n_bad + 1;
      $display("FAIL async_cnt_now: got %0h, expected 0", instr_count);
    end
    n_exp = 0;
    want(K_ACK, 0, "async_ack"); want(K_PC, 0, "async_pc"); want(K_CNT, 0, "async_cnt");
    want(K_PM, 0, "async_pm"); want(K_HALT, 0, "async_halted");
    tick_frozen();
    reset_n = 1'b1;
    want(K_PM, 1, "post_rst_pm");
    tick();

    // 6b: sync_reset while halted and while running
    halt_req = 1'b1;
    tick();
    want(K_HALT, 1, "sr_pre_halted"); want(K_PC, 2, "sr_pre_pc");
    sync_reset = 1'b1;
    want(K_PM, 0, "sr_halt_pm");
    tick_frozen();
    want(K_PC, 0, "sr_halt_pc"); want(K_HALT, 1, "sr_halt_state");
    sync_reset = 1'b0;
    want(K_PM, 0, "sr_after_pm");
    halt_req = 1'b0;
    tick_frozen();
    want(K_HALT, 0, "sr_run");
    sync_reset = 1'b1;
    want(K_PM, 0, "sr_run_pm");
    tick_frozen();
    want(K_CNT, n_exp, "sr_cnt_frozen"); want(K_PC, 0, "sr_run_pc");
    sync_reset = 1'b0;
    want(K_PM, 1, "sr_rel_pm");
    tick();
    want(K_CNT, n_exp, "final_cnt"); want(K_PC, 1, "final_pc"); want(K_FROM, 1, "final_from");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL queue_drain: %0d expectations not compared", q.size());
    end
    if (n_cmp < 12) begin
      n_bad = n_bad + 1;
      $display("FAIL too_few_compares: %0d", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    if (n_bad != 0) begin
      $fatal(1, "TEST FAILED");
    end else begin
      $display("TEST PASSED");
    end
    $finish;
  end

endmodule
